// File: rtl/bcd_entry_pkg.sv
// bcd_entry_pkg
//   Shared definitions for the keypad operand entry stage: key codes,
//   the controller state encoding and a small key classification helper.
//   Optional build macro used by bcd_entry: BCD_ENTRY_TIMEOUT_EN.
package bcd_entry_pkg;

    localparam logic [3:0] KEY_CLEAR = 4'hA;
    localparam logic [3:0] KEY_BKSP  = 4'hB;
    localparam logic [3:0] KEY_ENTER = 4'hC;

    typedef enum logic [1:0] {
        ST_ENTRY  = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2
    } state_e;

    // Codes 0..9 are decimal digits; everything above is a command or ignored.
    function automatic logic is_digit(input logic [3:0] code);
        return code <= 4'd9;
    endfunction

endpackage

// File: rtl/bcd_entry_digit_reg.sv
// bcd_digit_reg
//   Holds the packed BCD operand and its digit count. Executes one command
//   per cycle; priority is clr > load_first > shl > shr.
//   Ports:
//     clk, rst          clock, asynchronous active-low reset
//     shl               shift a digit in at the least significant end
//     shr               drop the least significant digit
//     clr               zero the operand and count
//     load_first        replace the operand with a single digit
//     digit [3:0]       digit used by shl / load_first
//     a [4*NDIG-1:0]    packed operand, digit 0 in bits [3:0]
//     ndig [2:0]        digits currently held
module bcd_digit_reg
    import bcd_entry_pkg::*;
#(
    parameter int NDIG = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                shl,
    input  logic                shr,
    input  logic                clr,
    input  logic                load_first,
    input  logic [3:0]          digit,
    output logic [4*NDIG-1:0]   a,
    output logic [2:0]          ndig
);

    logic [4*NDIG-1:0] a_q, a_d;
    logic [2:0]        ndig_q, ndig_d;

    always_comb begin
        a_d    = a_q;
        ndig_d = ndig_q;
        if (clr) begin
            a_d    = '0;
            ndig_d = 3'd0;
        end else if (load_first) begin
            a_d    = {{(4*NDIG-4){1'b0}}, digit};
            // A fresh zero is a leading zero: shown, but not counted.
            ndig_d = (digit == 4'd0) ? 3'd0 : 3'd1;
        end else if (shl) begin
            a_d    = {a_q[4*NDIG-5:0], digit};
            ndig_d = ndig_q + 3'd1;
        end else if (shr) begin
            a_d    = {4'h0, a_q[4*NDIG-1:4]};
            ndig_d = ndig_q - 3'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_q    <= '0;
            ndig_q <= 3'd0;
        end else begin
            a_q    <= a_d;
            ndig_q <= ndig_d;
        end
    end

    assign a    = a_q;
    assign ndig = ndig_q;

endmodule

// File: rtl/bcd_entry.sv
// bcd_entry
//   Keypad operand entry: accumulates up to NDIG BCD digits (most significant
//   first), and on ENTER launches the bcd2bin converter with INIT_CYC cycles
//   of init, then holds A stable until conv_done.
//   Optional feature macro: BCD_ENTRY_TIMEOUT_EN adds a WAIT timeout of
//   TIMEOUT cycles that returns to ENTRY and sets the sticky err flag.
//   Ports:
//     clk, rst        clock, asynchronous active-low reset
//     key_valid       one-cycle strobe qualifying key_code
//     key_code [3:0]  0-9 digit, A clear, B backspace, C enter, others ignored
//     conv_done       converter done (only honoured in WAIT)
//     A               packed BCD operand to the converter
//     init            converter start, high through LAUNCH
//     ndig            digits entered
//     busy            high in LAUNCH and WAIT
//     entry_done      one-cycle pulse after conv_done is accepted
//     key_drop        one-cycle pulse when a valid key is discarded
//     err             sticky timeout flag (constant 0 without the macro)
//     dbg_state       current controller state (state_e encoding)
//   Handshake: key_valid is a strobe with no back-pressure; a key that cannot
//   be used is reported on key_drop one cycle later. init/conv_done form a
//   start/done pair: init is level-high for INIT_CYC cycles, conv_done is
//   sampled only while waiting.
module bcd_entry
    import bcd_entry_pkg::*;
#(
    parameter int NDIG     = 5,
    parameter int INIT_CYC = 2,
    parameter int TIMEOUT  = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                key_valid,
    input  logic [3:0]          key_code,
    input  logic                conv_done,
    output logic [4*NDIG-1:0]   A,
    output logic                init,
    output logic [2:0]          ndig,
    output logic                busy,
    output logic                entry_done,
    output logic                key_drop,
    output logic                err,
    output logic [1:0]          dbg_state
);

    localparam int         CNT_W  = (INIT_CYC > 1) ? $clog2(INIT_CYC + 1) : 1;
    localparam logic [2:0] NDIG_L = 3'(NDIG);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   init_cnt_q, init_cnt_d;
    logic               fresh_q, fresh_d;
    logic               key_drop_q, key_drop_d;
    logic               entry_done_q, entry_done_d;
    logic               shl, shr, clr, load_first;

`ifdef BCD_ENTRY_TIMEOUT_EN
    localparam int      WAIT_W = $clog2(TIMEOUT + 1);
    logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic               err_q, err_d;
`endif

    always_comb begin
        state_d      = state_q;
        init_cnt_d   = init_cnt_q;
        fresh_d      = fresh_q;
        key_drop_d   = 1'b0;
        entry_done_d = 1'b0;
        shl          = 1'b0;
        shr          = 1'b0;
        clr          = 1'b0;
        load_first   = 1'b0;
`ifdef BCD_ENTRY_TIMEOUT_EN
        wait_cnt_d   = wait_cnt_q;
        err_d        = err_q;
`endif
        case (state_q)
            ST_ENTRY: begin
                if (key_valid) begin
                    if (is_digit(key_code)) begin
                        if (fresh_q) begin
                            // First digit after a conversion replaces the result.
                            load_first = 1'b1;
                            fresh_d    = 1'b0;
                        end else if (ndig == 3'd0 && key_code == 4'd0) begin
                            // Leading zero: silently ignored.
                        end else if (ndig < NDIG_L) begin
                            shl = 1'b1;
                        end else begin
                            key_drop_d = 1'b1;
                        end
                    end else if (key_code == KEY_BKSP) begin
                        shr = (ndig != 3'd0);
                    end else if (key_code == KEY_CLEAR) begin
                        clr     = 1'b1;
                        fresh_d = 1'b0;
`ifdef BCD_ENTRY_TIMEOUT_EN
                        err_d   = 1'b0;
`endif
                    end else if (key_code == KEY_ENTER) begin
                        state_d    = ST_LAUNCH;
                        init_cnt_d = '0;
                    end
                end
            end
            ST_LAUNCH: begin
                key_drop_d = key_valid;
                if (init_cnt_q == CNT_W'(INIT_CYC - 1)) begin
                    state_d    = ST_WAIT;
`ifdef BCD_ENTRY_TIMEOUT_EN
                    wait_cnt_d = '0;
`endif
                end else begin
                    init_cnt_d = init_cnt_q + 1'b1;
                end
            end
            ST_WAIT: begin
                key_drop_d = key_valid;
                if (conv_done) begin
                    state_d      = ST_ENTRY;
                    entry_done_d = 1'b1;
                    fresh_d      = 1'b1;
                end
`ifdef BCD_ENTRY_TIMEOUT_EN
                else if (wait_cnt_q == WAIT_W'(TIMEOUT - 1)) begin
                    // Give up on the converter; operand is kept, fresh untouched.
                    state_d = ST_ENTRY;
                    err_d   = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
`endif
            end
            default: state_d = ST_ENTRY;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_ENTRY;
            init_cnt_q   <= '0;
            fresh_q      <= 1'b0;
            key_drop_q   <= 1'b0;
            entry_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            init_cnt_q   <= init_cnt_d;
            fresh_q      <= fresh_d;
            key_drop_q   <= key_drop_d;
            entry_done_q <= entry_done_d;
        end
    end

`ifdef BCD_ENTRY_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            err_q      <= err_d;
        end
    end
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    bcd_digit_reg #(.NDIG(NDIG)) u_digit_reg (
        .clk        (clk),
        .rst        (rst),
        .shl        (shl),
        .shr        (shr),
        .clr        (clr),
        .load_first (load_first),
        .digit      (key_code),
        .a          (A),
        .ndig       (ndig)
    );

    // Decoded straight from the state flop so reset drops init without a clock.
    assign init       = (state_q == ST_LAUNCH);
    assign busy       = (state_q != ST_ENTRY);
    assign entry_done = entry_done_q;
    assign key_drop   = key_drop_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_bcd_entry.sv
module tb_bcd_entry;
    import bcd_entry_pkg::*;

    localparam int NDIG     = 5;
    localparam int INIT_CYC = 2;
    localparam int TIMEOUT  = 64;
    localparam int W        = 4 * NDIG;
    localparam int OBS_W    = W + 8;

    // ---------------- clock / reset ----------------
    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         key_valid = 1'b0;
    logic [3:0]   key_code = 4'd0;
    logic         conv_done = 1'b0;
    logic [W-1:0] A;
    logic         init, busy, entry_done, key_drop, err;
    logic [2:0]   ndig;
    logic [1:0]   dbg_state;

    always #5 clk = ~clk;

    bcd_entry #(.NDIG(NDIG), .INIT_CYC(INIT_CYC), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .rst        (rst),
        .key_valid  (key_valid),
        .key_code   (key_code),
        .conv_done  (conv_done),
        .A          (A),
        .init       (init),
        .ndig       (ndig),
        .busy       (busy),
        .entry_done (entry_done),
        .key_drop   (key_drop),
        .err        (err),
        .dbg_state  (dbg_state)
    );

    logic [OBS_W-1:0] obs;
    assign obs = {A, ndig, init, busy, entry_done, key_drop, err};

    int tests_run = 0;
    int fails     = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // ---------------- driver ----------------
    // Inputs are presented before the edge; outputs are sampled 1 ns after it.
    task automatic cycle(input logic kv, input logic [3:0] code, input logic done);
        key_valid = kv;
        key_code  = code;
        conv_done = done;
        @(posedge clk);
        #1;
        key_valid = 1'b0;
        key_code  = 4'd0;
        conv_done = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("reset_outputs", 64'(obs), 64'(0));
        check("reset_state", 64'(dbg_state), 64'(ST_ENTRY));
        rst = 1'b1;
    endtask

    // ---------------- reference model ----------------
    // Operand kept as a list of entered digits, most significant first.
    int  m_dig[$];
    bit  m_fresh, m_err, m_wait, m_ed, m_kd;
    int  m_launch, m_wcnt;
    logic [W-1:0] exp_q[$];

    function automatic logic [W-1:0] model_a();
        logic [W-1:0] a = '0;
        foreach (m_dig[i]) a = a * 16 + W'(m_dig[i]);
        return a;
    endfunction

    function automatic logic [OBS_W-1:0] model_obs();
        return {model_a(), 3'(m_dig.size()), (m_launch > 0), (m_launch > 0) || m_wait,
                m_ed, m_kd, m_err};
    endfunction

    task automatic model_reset();
        m_dig.delete();
        exp_q.delete();
        m_fresh = 0; m_err = 0; m_wait = 0; m_ed = 0; m_kd = 0;
        m_launch = 0; m_wcnt = 0;
    endtask

    task automatic model_step(input bit kv, input logic [3:0] code, input bit done);
        m_ed = 0;
        m_kd = 0;
        if (m_launch > 0) begin
            if (kv) m_kd = 1;
            m_launch--;
            if (m_launch == 0) begin
                m_wait = 1;
                m_wcnt = 0;
            end
        end else if (m_wait) begin
            if (kv) m_kd = 1;
            if (done) begin
                m_wait  = 0;
                m_ed    = 1;
                m_fresh = 1;
            end
`ifdef BCD_ENTRY_TIMEOUT_EN
            else begin
                m_wcnt++;
                if (m_wcnt == TIMEOUT) begin
                    m_wait = 0;
                    m_err  = 1;
                end
            end
`endif
        end else if (kv) begin
            if (code <= 4'd9) begin
                if (m_fresh) begin
                    m_dig.delete();
                    if (code != 0) m_dig.push_back(int'(code));
                    m_fresh = 0;
                end else if (m_dig.size() == 0 && code == 0) begin
                end else if (m_dig.size() < NDIG) begin
                    m_dig.push_back(int'(code));
                end else begin
                    m_kd = 1;
                end
            end else if (code == KEY_BKSP) begin
                if (m_dig.size() > 0) void'(m_dig.pop_back());
            end else if (code == KEY_CLEAR) begin
                m_dig.delete();
                m_fresh = 0;
                m_err   = 0;
            end else if (code == KEY_ENTER) begin
                m_launch = INIT_CYC;
                exp_q.push_back(model_a());
            end
        end
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic         kv;
        logic [3:0]   code;
        logic         done;
        logic [W-1:0] a;
        logic [2:0]   nd;
        logic         ini;
        logic         bsy;
        logic         ed;
        logic         kd;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic kv, input logic [3:0] code, input logic done,
                       input logic [W-1:0] a, input logic [2:0] nd, input logic ini,
                       input logic bsy, input logic ed, input logic kd);
        vec_t v;
        v.kv = kv; v.code = code; v.done = done; v.a = a; v.nd = nd;
        v.ini = ini; v.bsy = bsy; v.ed = ed; v.kd = kd;
        tbl.push_back(v);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic prev_init;
        bit   saw_ed;

        // kv code done | A ndig init busy ed kd
        add(1, 4'h3, 0, 20'h00003, 1, 0, 0, 0, 0);
        add(1, 4'h5, 0, 20'h00035, 2, 0, 0, 0, 0);
        add(1, 4'h7, 0, 20'h00357, 3, 0, 0, 0, 0);
        add(1, 4'h8, 0, 20'h03578, 4, 0, 0, 0, 0);
        add(1, 4'h9, 0, 20'h35789, 5, 0, 0, 0, 0);
        add(1, 4'hC, 0, 20'h35789, 5, 1, 1, 0, 0);   // ENTER with full buffer
        add(0, 4'h0, 0, 20'h35789, 5, 1, 1, 0, 0);
        add(0, 4'h0, 0, 20'h35789, 5, 0, 1, 0, 0);   // WAIT
        add(1, 4'h7, 0, 20'h35789, 5, 0, 1, 0, 1);   // digit dropped
        add(1, 4'hA, 0, 20'h35789, 5, 0, 1, 0, 1);   // CLEAR dropped
        add(1, 4'h2, 1, 20'h35789, 5, 0, 0, 1, 1);   // key on conv_done edge
        add(0, 4'h0, 0, 20'h35789, 5, 0, 0, 0, 0);
        add(1, 4'h9, 0, 20'h00009, 1, 0, 0, 0, 0);   // fresh replace
        add(1, 4'hA, 0, 20'h00000, 0, 0, 0, 0, 0);
        add(1, 4'h0, 0, 20'h00000, 0, 0, 0, 0, 0);   // leading zeros
        add(1, 4'h0, 0, 20'h00000, 0, 0, 0, 0, 0);
        add(1, 4'h4, 0, 20'h00004, 1, 0, 0, 0, 0);
        add(1, 4'h2, 0, 20'h00042, 2, 0, 0, 0, 0);
        add(1, 4'hB, 0, 20'h00004, 1, 0, 0, 0, 0);
        add(1, 4'hA, 0, 20'h00000, 0, 0, 0, 0, 0);
        add(1, 4'h1, 0, 20'h00001, 1, 0, 0, 0, 0);
        add(1, 4'h2, 0, 20'h00012, 2, 0, 0, 0, 0);
        add(1, 4'h3, 0, 20'h00123, 3, 0, 0, 0, 0);
        add(1, 4'h4, 0, 20'h01234, 4, 0, 0, 0, 0);
        add(1, 4'h5, 0, 20'h12345, 5, 0, 0, 0, 0);
        add(1, 4'h6, 0, 20'h12345, 5, 0, 0, 0, 1);   // overflow drop
        add(1, 4'hA, 0, 20'h00000, 0, 0, 0, 0, 0);
        add(1, 4'hB, 0, 20'h00000, 0, 0, 0, 0, 0);   // backspace at zero
        add(1, 4'h1, 0, 20'h00001, 1, 0, 0, 0, 0);
        add(1, 4'h2, 0, 20'h00012, 2, 0, 0, 0, 0);
        add(1, 4'hC, 0, 20'h00012, 2, 1, 1, 0, 0);
        add(0, 4'h0, 0, 20'h00012, 2, 1, 1, 0, 0);
        add(0, 4'h0, 0, 20'h00012, 2, 0, 1, 0, 0);
        add(0, 4'h0, 1, 20'h00012, 2, 0, 0, 1, 0);
        add(1, 4'h9, 0, 20'h00009, 1, 0, 0, 0, 0);   // fresh replace
        add(1, 4'hB, 0, 20'h00000, 0, 0, 0, 0, 0);
        add(1, 4'hC, 0, 20'h00000, 0, 1, 1, 0, 0);   // ENTER at ndig=0
        add(0, 4'h0, 1, 20'h00000, 0, 1, 1, 0, 0);   // done ignored in LAUNCH
        add(0, 4'h0, 1, 20'h00000, 0, 0, 1, 0, 0);
        add(0, 4'h0, 1, 20'h00000, 0, 0, 0, 1, 0);
        add(1, 4'hE, 0, 20'h00000, 0, 0, 0, 0, 0);   // unused code ignored

        do_reset();
        for (int i = 0; i < tbl.size(); i++) begin
            cycle(tbl[i].kv, tbl[i].code, tbl[i].done);
            check($sformatf("vec%0d", i), 64'(obs),
                  64'({tbl[i].a, tbl[i].nd, tbl[i].ini, tbl[i].bsy, tbl[i].ed, tbl[i].kd, 1'b0}));
        end

        // Asynchronous reset while init is high.
        cycle(1, 4'h5, 0);
        cycle(1, KEY_ENTER, 0);
        check("launch_init", 64'({init, busy, A}), 64'({1'b1, 1'b1, 20'h00005}));
        #2;
        rst = 1'b0;
        #1;
        check("async_reset_outputs", 64'(obs), 64'(0));
        check("async_reset_state", 64'(dbg_state), 64'(ST_ENTRY));
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Converter that never answers.
        cycle(1, 4'h7, 0);
        cycle(1, KEY_ENTER, 0);
        saw_ed = 0;
`ifdef BCD_ENTRY_TIMEOUT_EN
        for (int i = 1; i <= INIT_CYC + TIMEOUT; i++) begin
            cycle(0, 4'h0, 0);
            if (entry_done) saw_ed = 1;
            if (i == INIT_CYC + TIMEOUT - 1)
                check("timeout_still_busy", 64'({busy, err}), 64'({1'b1, 1'b0}));
        end
        check("timeout_exit", 64'({busy, err, dbg_state}), 64'({1'b0, 1'b1, ST_ENTRY}));
        check("timeout_no_entry_done", 64'(saw_ed), 64'(0));
        check("timeout_keeps_a", 64'(A), 64'(20'h00007));
        cycle(1, KEY_CLEAR, 0);
        check("clear_clears_err", 64'({err, A}), 64'(0));
`else
        for (int i = 0; i < 100; i++) begin
            cycle(0, 4'h0, 0);
            if (entry_done) saw_ed = 1;
        end
        check("no_timeout_busy", 64'({busy, err, dbg_state}), 64'({1'b1, 1'b0, ST_WAIT}));
        check("no_timeout_no_entry_done", 64'(saw_ed), 64'(0));
        cycle(0, 4'h0, 1);
        check("late_done", 64'({busy, entry_done, A}), 64'({1'b0, 1'b1, 20'h00007}));
`endif

        // Randomized run against the reference model.
        do_reset();
        model_reset();
        prev_init = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            logic       kv, done;
            logic [3:0] code;
            int         r;
            kv = ($urandom_range(0, 2) != 0);
            r  = $urandom_range(0, 99);
            if (r < 70)      code = 4'($urandom_range(0, 9));
            else if (r < 78) code = KEY_BKSP;
            else if (r < 82) code = KEY_CLEAR;
            else if (r < 93) code = KEY_ENTER;
            else             code = 4'($urandom_range(13, 15));
            done = ($urandom_range(0, 5) == 0);
            model_step(kv, code, done);
            cycle(kv, code, done);
            check($sformatf("rand%0d", n), 64'(obs), 64'(model_obs()));
            if (init && !prev_init) begin
                if (exp_q.size() == 0) begin
                    check($sformatf("launch_unexpected%0d", n), 64'(1), 64'(0));
                end else begin
                    check($sformatf("launch_a%0d", n), 64'(A), 64'(exp_q.pop_front()));
                end
            end
            prev_init = init;
        end
        check("launch_queue_drained", 64'(exp_q.size()), 64'(0));

        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
